// File: rtl/m68k_region_decoder.sv
// Run-time programmable 68000 chip-select decoder with wait states and bus-error timeout.
// Optional error log is enabled by defining M68K_REGION_DECODER_ERRLOG_EN.
module m68k_region_decoder #(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT     = 255,
    localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      m68k_a,
    input  logic                   m68k_as_n,
    input  logic                   m68k_rw,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic                   cfg_en,
    input  logic [ADDR_W-1:0]      cfg_base,
    input  logic [ADDR_W-1:0]      cfg_mask,
    input  logic [WAIT_W-1:0]      cfg_wait,
    input  logic [1:0]             cfg_rw_mode,
    output logic [NUM_REGIONS-1:0] cs,
    output logic [IDX_W-1:0]       hit_idx,
    output logic                   dtack_n,
    output logic                   berr_n,
`ifdef M68K_REGION_DECODER_ERRLOG_EN
    input  logic                   err_clr,
    output logic [ADDR_W-1:0]      err_addr,
    output logic                   err_rw,
    output logic                   err_valid,
    output logic [7:0]             err_count,
`endif
    output logic                   busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ACK    = 3'd3;
    localparam logic [2:0] S_TMO    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (WAIT_W > TMO_W) ? WAIT_W : TMO_W;
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);
    localparam logic [IDX_W:0]   NREG     = (IDX_W + 1)'(NUM_REGIONS);

    // Region table; only the enables need a reset value
    logic [NUM_REGIONS-1:0]             en_q, en_d;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] base_q, base_d;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] mask_q, mask_d;
    logic [NUM_REGIONS-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic [NUM_REGIONS-1:0][1:0]        rwm_q, rwm_d;

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic                   dtack_n_q, dtack_n_d;
    logic                   berr_n_q, berr_n_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rw_q, rw_d;

    logic [NUM_REGIONS-1:0] match;
    logic                   hit;
    logic [IDX_W-1:0]       hit_sel;
    logic [WAIT_W-1:0]      wait_sel;
    logic [NUM_REGIONS-1:0] cs_hit;
    logic                   release_bus;

    // Table update: writes land at the edge, so the decode sees the old table
    always_comb begin
        en_d   = en_q;
        base_d = base_q;
        mask_d = mask_q;
        wait_d = wait_q;
        rwm_d  = rwm_q;
        if (cfg_we && ({1'b0, cfg_idx} < NREG)) begin
            en_d[cfg_idx]   = cfg_en;
            base_d[cfg_idx] = cfg_base;
            mask_d[cfg_idx] = cfg_mask;
            wait_d[cfg_idx] = cfg_wait;
            rwm_d[cfg_idx]  = cfg_rw_mode;
        end
    end

    // Per-region match against the captured address and direction
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            match[i] = en_q[i]
                && ((addr_q & mask_q[i]) == (base_q[i] & mask_q[i]))
                && ((rwm_q[i] == 2'b00)
                    || ((rwm_q[i] == 2'b01) && rw_q)
                    || ((rwm_q[i] == 2'b10) && !rw_q));
        end
    end

    // Priority select: the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_sel = IDX_W'(i);
            end
        end
    end

    assign wait_sel = wait_q[hit_sel];
    assign cs_hit   = {{(NUM_REGIONS-1){1'b0}}, 1'b1} << hit_sel;

    // Bus cycle state machine
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_d        = cs_q;
        hit_idx_d   = hit_idx_q;
        dtack_n_d   = dtack_n_q;
        berr_n_d    = berr_n_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        release_bus = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!m68k_as_n) begin
                    addr_d  = m68k_a;
                    rw_d    = m68k_rw;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (m68k_as_n) begin
                    release_bus = 1'b1;
                end else if (hit) begin
                    cs_d      = cs_hit;
                    hit_idx_d = hit_sel;
                    if (wait_sel == '0) begin
                        dtack_n_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        cnt_d   = CNT_W'(wait_sel);
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d   = TMO_LOAD;
                    state_d = S_TMO;
                end
            end
            S_WAIT: begin
                if (m68k_as_n) begin
                    release_bus = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    dtack_n_d = 1'b0;
                    state_d   = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_TMO: begin
                if (m68k_as_n) begin
                    release_bus = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    berr_n_d = 1'b0;
                    state_d  = S_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK, S_ERR: begin
                release_bus = m68k_as_n;
            end
            default: begin
                release_bus = 1'b1;
            end
        endcase
        if (release_bus) begin
            state_d   = S_IDLE;
            cs_d      = '0;
            hit_idx_d = '0;
            dtack_n_d = 1'b1;
            berr_n_d  = 1'b1;
        end
    end

    // Registered state and outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cs_q      <= '0;
            hit_idx_q <= '0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            en_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cs_q      <= cs_d;
            hit_idx_q <= hit_idx_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            en_q      <= en_d;
        end
    end

    // Table payload registers, meaningless until their enable is set
    always_ff @(posedge clk) begin
        base_q <= base_d;
        mask_q <= mask_d;
        wait_q <= wait_d;
        rwm_q  <= rwm_d;
    end

    assign cs      = cs_q;
    assign hit_idx = hit_idx_q;
    assign dtack_n = dtack_n_q;
    assign berr_n  = berr_n_q;
    assign busy    = (state_q != S_IDLE);

`ifdef M68K_REGION_DECODER_ERRLOG_EN
    logic              to_err;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              err_rw_q, err_rw_d;
    logic              err_valid_q, err_valid_d;
    logic [7:0]        err_count_q, err_count_d;

    assign to_err = (state_q == S_TMO) && (state_d == S_ERR);

    // Error log: a capture on entry to ERR takes precedence over a clear
    always_comb begin
        err_addr_d  = err_addr_q;
        err_rw_d    = err_rw_q;
        err_valid_d = err_valid_q;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_valid_d = 1'b0;
            err_count_d = 8'd0;
        end
        if (to_err) begin
            err_addr_d  = addr_q;
            err_rw_d    = rw_q;
            err_valid_d = 1'b1;
            if (err_clr) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // Error log registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_addr_q  <= '0;
            err_rw_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_rw_q    <= err_rw_d;
            err_valid_q <= err_valid_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_rw    = err_rw_q;
    assign err_valid = err_valid_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Self-checking bench for m68k_region_decoder.
// Expected responses are queued at stimulus time and popped when the bus responds.
module tb_m68k_region_decoder;

    localparam int NR  = 16;
    localparam int AW  = 24;
    localparam int WW  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] m68k_a;
    logic          m68k_as_n;
    logic          m68k_rw;
    logic          cfg_we;
    logic [3:0]    cfg_idx;
    logic          cfg_en;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_mask;
    logic [WW-1:0] cfg_wait;
    logic [1:0]    cfg_rw_mode;
    logic [NR-1:0] cs;
    logic [3:0]    hit_idx;
    logic          dtack_n;
    logic          berr_n;
    logic          busy;
`ifdef M68K_REGION_DECODER_ERRLOG_EN
    logic          err_clr;
    logic [AW-1:0] err_addr;
    logic          err_rw;
    logic          err_valid;
    logic [7:0]    err_count;
`endif

    m68k_region_decoder #(
        .NUM_REGIONS(NR),
        .ADDR_W(AW),
        .WAIT_W(WW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m68k_a(m68k_a),
        .m68k_as_n(m68k_as_n),
        .m68k_rw(m68k_rw),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_en(cfg_en),
        .cfg_base(cfg_base),
        .cfg_mask(cfg_mask),
        .cfg_wait(cfg_wait),
        .cfg_rw_mode(cfg_rw_mode),
        .cs(cs),
        .hit_idx(hit_idx),
        .dtack_n(dtack_n),
        .berr_n(berr_n),
`ifdef M68K_REGION_DECODER_ERRLOG_EN
        .err_clr(err_clr),
        .err_addr(err_addr),
        .err_rw(err_rw),
        .err_valid(err_valid),
        .err_count(err_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         berr;
        logic [15:0] cs;
        logic [3:0] idx;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   edge_n  = 0;
    int   inv_bad = 0;

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        if (reset_n && ((!berr_n && cs != '0) || $countones(cs) > 1))
            inv_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int idx, input bit en, input logic [23:0] base,
                       input logic [23:0] mask, input logic [3:0] w,
                       input logic [1:0] mode);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_idx     = 4'(idx);
        cfg_en      = en;
        cfg_base    = base;
        cfg_mask    = mask;
        cfg_wait    = w;
        cfg_rw_mode = mode;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    function automatic exp_t hit_exp(input int idx, input int w);
        exp_t e;
        e.berr = 1'b0;
        e.cs   = 16'(1) << idx;
        e.idx  = 4'(idx);
        e.lat  = 1 + w;
        return e;
    endfunction

    function automatic exp_t miss_exp();
        exp_t e;
        e.berr = 1'b1;
        e.cs   = '0;
        e.idx  = '0;
        e.lat  = 1 + TMO;
        return e;
    endfunction

    // One full bus cycle; dis0 disables region 0 during the DECODE cycle
    task automatic bus_cycle(input string tag, input logic [23:0] a,
                             input bit rw, input exp_t e, input bit dis0);
        exp_t x;
        int   e0;
        bit   done;
        done = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        m68k_a    = a;
        m68k_rw   = rw;
        m68k_as_n = 1'b0;
        e0        = edge_n + 1;
        @(negedge clk);
        m68k_a = ~a;
        if (dis0) begin
            cfg_we  = 1'b1;
            cfg_idx = 4'd0;
            cfg_en  = 1'b0;
        end
        @(negedge clk);
        cfg_we = 1'b0;
        chk({tag, "_cs_e1"}, 32'(cs), 32'(e.cs));
        for (int k = 0; k < 40 && !done; k++) begin
            if (!dtack_n || !berr_n) done = 1'b1;
            else @(negedge clk);
        end
        x = sb.pop_front();
        chk({tag, "_responded"}, 32'(done), 32'd1);
        chk({tag, "_berr"}, 32'(!berr_n), 32'(x.berr));
        chk({tag, "_dtack"}, 32'(!dtack_n), 32'(!x.berr));
        chk({tag, "_lat"}, 32'(edge_n - e0), 32'(x.lat));
        chk({tag, "_cs"}, 32'(cs), 32'(x.cs));
        if (!x.berr) chk({tag, "_idx"}, 32'(hit_idx), 32'(x.idx));
        m68k_as_n = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {12'h0, cs, dtack_n, berr_n, busy},
            {12'h0, 16'h0, 1'b1, 1'b1, 1'b0});
    endtask

    initial begin
        int seen;
        reset_n     = 1'b0;
        m68k_a      = '0;
        m68k_as_n   = 1'b1;
        m68k_rw     = 1'b1;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_en      = 1'b0;
        cfg_base    = '0;
        cfg_mask    = '0;
        cfg_wait    = '0;
        cfg_rw_mode = '0;
`ifdef M68K_REGION_DECODER_ERRLOG_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_out", {12'h0, cs, dtack_n, berr_n, busy},
            {12'h0, 16'h0, 1'b1, 1'b1, 1'b0});
        chk("reset_idx", 32'(hit_idx), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        cfg(0, 1, 24'h000000, 24'hFC0000, 4'd0, 2'b00);
        cfg(2, 1, 24'h400000, 24'hFFE000, 4'd3, 2'b00);
        cfg(1, 1, 24'h100000, 24'hFFF000, 4'd1, 2'b00);
        cfg(5, 1, 24'h100000, 24'hF00000, 4'd0, 2'b00);
        cfg(3, 1, 24'h080000, 24'hFF0000, 4'd2, 2'b01);
        cfg(4, 1, 24'h600000, 24'hFF0000, 4'd0, 2'b10);
        cfg(6, 1, 24'h700000, 24'hFF0000, 4'd0, 2'b11);
        cfg(7, 1, 24'h900000, 24'hFF0000, 4'd7, 2'b00);

        bus_cycle("r0_read", 24'h012345, 1'b1, hit_exp(0, 0), 1'b0);
        bus_cycle("r2_wait3", 24'h401FFE, 1'b0, hit_exp(2, 3), 1'b0);
        bus_cycle("ovl_r1", 24'h100800, 1'b1, hit_exp(1, 1), 1'b0);
        bus_cycle("ovl_r5", 24'h180000, 1'b1, hit_exp(5, 0), 1'b0);
        bus_cycle("ro_write", 24'h080000, 1'b0, miss_exp(), 1'b0);
`ifdef M68K_REGION_DECODER_ERRLOG_EN
        chk("log_addr", 32'(err_addr), 32'h080000);
        chk("log_rw", 32'(err_rw), 32'd0);
        chk("log_valid", 32'(err_valid), 32'd1);
        chk("log_count", 32'(err_count), 32'd1);
`endif
        bus_cycle("ro_read", 24'h080000, 1'b1, hit_exp(3, 2), 1'b0);
        bus_cycle("wo_read", 24'h600000, 1'b1, miss_exp(), 1'b0);
        bus_cycle("wo_write", 24'h600000, 1'b0, hit_exp(4, 0), 1'b0);
        bus_cycle("rsvd", 24'h700000, 1'b1, miss_exp(), 1'b0);
        bus_cycle("unmapped", 24'hF00000, 1'b0, miss_exp(), 1'b0);

        // Abort during wait states: strobe dropped after E3
        @(negedge clk);
        m68k_a    = 24'h900010;
        m68k_rw   = 1'b1;
        m68k_as_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_cs", 32'(cs), 32'h0080);
        m68k_as_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {12'h0, cs, dtack_n, berr_n, busy},
            {12'h0, 16'h0, 1'b1, 1'b1, 1'b0});
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (!dtack_n || busy) seen++;
        end
        chk("abort_no_dtack", 32'(seen), 32'd0);

        bus_cycle("dis_in_dec", 24'h012345, 1'b1, hit_exp(0, 0), 1'b1);
        bus_cycle("after_dis", 24'h012345, 1'b1, miss_exp(), 1'b0);
`ifdef M68K_REGION_DECODER_ERRLOG_EN
        chk("log_count5", 32'(err_count), 32'd5);
        chk("log_addr2", 32'(err_addr), 32'h012345);
        chk("log_rw2", 32'(err_rw), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("log_clr", {err_valid, err_count}, 32'd0);
`endif

        // Reset in the middle of a wait-state cycle
        @(negedge clk);
        m68k_a    = 24'h900000;
        m68k_as_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n   = 1'b0;
        m68k_as_n = 1'b1;
        @(negedge clk);
        chk("midreset", {12'h0, cs, dtack_n, berr_n, busy},
            {12'h0, 16'h0, 1'b1, 1'b1, 1'b0});
        reset_n = 1'b1;
        bus_cycle("post_reset", 24'h400000, 1'b1, miss_exp(), 1'b0);

        chk("invariant", 32'(inv_bad), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
